// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_if
// Brief   : Command/response handshake and SPI pin bundle for spi_master.
//           The master modport is the controller view, the slave modport is
//           the host/slave-model view.
// Revision: 1.0  initial release
// ============================================================================
interface spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_type, cmd_data, MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_data, MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module  : spi_master
// Brief   : Single-frame SPI master. Sends a 10-bit word {cmd_type,cmd_data}
//           preceded by a copy of its top bit; read-data frames then wait
//           RD_WAIT cycles and capture one byte from MISO (MSB first).
//           Optional macro SPI_MASTER_STATS_EN adds the frame_cnt output.
// Revision: 1.0  initial release
// ============================================================================
module spi_master #(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
`ifdef SPI_MASTER_STATS_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Counters hold "cycles remaining minus one" so each state exits at zero.
  localparam logic [3:0] C_SHIFT_LOAD   = 4'd9;
  localparam logic [3:0] C_WAIT_LOAD    = 4'(RD_WAIT - 1);
  localparam logic [3:0] C_CAPTURE_LOAD = 4'd7;
  localparam logic [3:0] C_GAP_LOAD     = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] w_q, w_d;
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  // Next-state, counter, capture and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    shreg_d     = shreg_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_d     = {bus.cmd_type, bus.cmd_data};
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        state_d = ST_SHIFT;
        cnt_d   = C_SHIFT_LOAD;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (w_q[9:8] == 2'b11) begin
            state_d = ST_WAIT;
            cnt_d   = C_WAIT_LOAD;
          end else begin
            state_d = ST_GAP;
            cnt_d   = C_GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
          cnt_d   = C_CAPTURE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        shreg_d = {shreg_q[5:0], bus.MISO};
        if (cnt_q == 4'd0) begin
          // Publish the whole byte at once, together with the pulse.
          rsp_data_d  = {shreg_q, bus.MISO};
          rsp_valid_d = 1'b1;
          state_d     = ST_GAP;
          cnt_d       = C_GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Pin values are derived from the state being entered so they register
    // in step with the state itself.
    ss_n_d = 1'b1;
    mosi_d = 1'b0;
    case (state_d)
      ST_CMD: begin
        ss_n_d = 1'b0;
        mosi_d = w_d[9];
      end
      ST_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = w_q[cnt_d];
      end
      ST_WAIT, ST_CAPTURE: begin
        ss_n_d = 1'b0;
      end
      default: begin
        ss_n_d = 1'b1;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      w_q         <= 10'd0;
      shreg_q     <= 7'd0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      shreg_q     <= shreg_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;

`ifdef SPI_MASTER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // A frame's last SS_n-low cycle is the one whose closing edge enters GAP.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
